// File: rtl/seq_div_pkg.sv
// Shared constants and state encoding for the 16/8 sequential divider.
package seq_div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int STEPS      = 8;
  localparam int CNT_W      = 3;

  localparam logic [7:0] ERR_QUOT = 8'hFF;
  localparam logic [7:0] ERR_REM  = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_16_8_step.sv
// One combinational restoring-division iteration.
module div_step (
  input  logic [8:0] p,
  input  logic       qmsb,
  input  logic [7:0] d,
  output logic [8:0] p_next,
  output logic       qbit
);

  logic [9:0] t;

  // p[8] is always 0 under P<D, kept in the compare for exactness
  always_comb begin
    t      = {p, qmsb};
    qbit   = (t >= {2'b00, d});
    p_next = qbit ? (t[8:0] - {1'b0, d}) : t[8:0];
  end

endmodule

// File: rtl/seq_div_16_8.sv
// Sequential restoring divider, 16-bit by 8-bit, valid/ready on both sides.
module seq_div_16_8
  import seq_div_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           quotient,
  output logic [7:0]           remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  state_t           state_q, state_d;
  logic [8:0]       p_q, p_d;
  logic [7:0]       q_q, q_d;
  logic [7:0]       d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [8:0] step_p;
  logic       step_qbit;

  div_step u_step (
    .p      (p_q),
    .qmsb   (q_q[7]),
    .d      (d_q),
    .p_next (step_p),
    .qbit   (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d     = divisor;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = CALC;
          if (divisor == '0) begin
            dbz_d = 1'b1;
            err_d = 1'b1;
            q_d   = ERR_QUOT;
            p_d   = {1'b0, ERR_REM};
          end else if (dividend[15:8] >= divisor) begin
            ovf_d = 1'b1;
            err_d = 1'b1;
            q_d   = ERR_QUOT;
            p_d   = {1'b0, ERR_REM};
          end else begin
            p_d = {1'b0, dividend[15:8]};
            q_d = dividend[7:0];
          end
        end
      end
      CALC: begin
        // error results are already loaded; spend one cycle then present
        if (err_q) begin
          state_d = DONE;
        end else begin
          p_d   = step_p;
          q_d   = {q_q[6:0], step_qbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STEPS - 1))
            state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = p_q[7:0];
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div_16_8.sv
// Directed self-checking bench for seq_div_16_8.
module tb_seq_div_16_8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  seq_div_16_8 dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // accept edge is E0; returns #1 after it
  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    tick();
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 8'hA5;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (quotient !== 8'h00 || remainder !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: q=%h r=%h want 00 00", quotient, remainder);
    end
    checks++;
    if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: dbz=%b ovf=%b want 0 0", div_by_zero, overflow);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_exact();
    out_ready = 1'b1;
    start_op(16'h6018, 8'h7B);
    for (int e = 1; e <= 9; e++) begin
      checks++;
      if (e <= 8 && in_ready !== 1'b0) begin
        failures++;
        $display("FAIL exact_inready_E%0d: got %b want 0", e - 1, in_ready);
      end
      if (e == 8) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL exact_early_valid: got %b want 0", out_valid);
        end
      end
      tick();
    end
    // now #1 after E8... one more loop ran tick after e=9 check; recheck position
  endtask

  task automatic test_exact_timing();
    out_ready = 1'b1;
    start_op(16'h6018, 8'h7B);
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL exact_inready_E%0d: got %b want 0", e, in_ready);
      end
      if (e == 7) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL exact_early_valid: got %b want 0", out_valid);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || quotient !== 8'hC8 || remainder !== 8'h00) begin
      failures++;
      $display("FAIL exact_result: v=%b q=%h r=%h want 1 c8 00", out_valid, quotient, remainder);
    end
    checks++;
    if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL exact_flags: dbz=%b ovf=%b want 0 0", div_by_zero, overflow);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL exact_after_E9: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] dd [3] = '{16'h6019, 16'hFE01, 16'h7AFF};
    logic [7:0]  dv [3] = '{8'h7B, 8'hFF, 8'h7B};
    logic [7:0]  eq [3] = '{8'hC8, 8'hFF, 8'hFF};
    logic [7:0]  er [3] = '{8'h01, 8'h00, 8'h7A};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_op(dd[i], dv[i]);
      for (int e = 1; e <= 8; e++) tick();
      checks++;
      if (out_valid !== 1'b1 || quotient !== eq[i] || remainder !== er[i]) begin
        failures++;
        $display("FAIL vec%0d_result: v=%b q=%h r=%h want 1 %h %h",
                 i, out_valid, quotient, remainder, eq[i], er[i]);
      end
      checks++;
      if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_flags: dbz=%b ovf=%b want 0 0", i, div_by_zero, overflow);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    out_ready = 1'b1;
    start_op(16'h1234, 8'h00);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL dbz_valid_E0: got %b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL dbz_flags: v=%b dbz=%b ovf=%b want 1 1 0", out_valid, div_by_zero, overflow);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'h00) begin
      failures++;
      $display("FAIL dbz_result: q=%h r=%h want ff 00", quotient, remainder);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL dbz_after_E2: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    start_op(16'h7B00, 8'h7B);
    tick();
    checks++;
    if (out_valid !== 1'b1 || overflow !== 1'b1 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL ovf_flags: v=%b ovf=%b dbz=%b want 1 1 0", out_valid, overflow, div_by_zero);
    end
    checks++;
    if (quotient !== 8'hFF || remainder !== 8'h00) begin
      failures++;
      $display("FAIL ovf_result: q=%h r=%h want ff 00", quotient, remainder);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int budget;
    out_ready = 1'b0;
    start_op(16'h6019, 8'h7B);
    budget = 0;
    while (out_valid !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_timeout: out_valid=%b want 1", out_valid);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      dividend = 16'h0100;
      divisor  = 8'h02;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          quotient !== 8'hC8 || remainder !== 8'h01 ||
          div_by_zero !== 1'b0 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: v=%b rdy=%b q=%h r=%h dbz=%b ovf=%b want 1 0 c8 01 0 0",
                 c, out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start_op(16'h6018, 8'h7B);
    for (int e = 1; e <= 4; e++) tick();
    RST = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || quotient !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_clear: v=%b q=%h rdy=%b want 0 00 1", out_valid, quotient, in_ready);
    end
    tick();
    RST = 1'b0;
    tick();
    start_op(16'h6018, 8'h7B);
    for (int e = 1; e <= 8; e++) tick();
    checks++;
    if (out_valid !== 1'b1 || quotient !== 8'hC8 || remainder !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_next: v=%b q=%h r=%h want 1 c8 00", out_valid, quotient, remainder);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_exact_timing();
    test_vectors();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
